// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between WB and a long-latency FIFO.
// Latency: WB writes land 1 cycle after WB_V; FIFO results land at least 2 cycles after LU_V.
// Backpressure: LU_READY drops when the FIFO is full; PIPE_HOLD asks the pipeline for a WB bubble.
module regfile_wr_arbiter #(
   parameter int XLEN         = 64,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            WB_V,
   input  logic            WB_WEN,
   input  logic [4:0]      WB_DR,
   input  logic [XLEN-1:0] WB_DATA,
   input  logic            LU_V,
   input  logic [4:0]      LU_DR,
   input  logic [XLEN-1:0] LU_DATA,
   output logic            LU_READY,
   input  logic [4:0]      SR1,
   input  logic [4:0]      SR2,
   output logic            PEND1,
   output logic            PEND2,
   output logic            PIPE_HOLD,
   output logic [4:0]      OUT_DE_DR,
   output logic [XLEN-1:0] OUT_DE_Data,
   output logic            OUT_DE_REG_WEN,
   output logic            ERR
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

   typedef enum logic {ARB = 1'b0, DRAIN = 1'b1} state_t;

   state_t state, state_nxt;

   logic [4:0]      mem_dr   [DEPTH];
   logic [XLEN-1:0] mem_data [DEPTH];
   logic [DEPTH-1:0] ent_vld;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, count_nxt;
   logic [SW-1:0]   starve_cnt, starve_nxt;

   logic push, enq, wb_req, wb_viol, fifo_empty, pop;
   logic fifo_hit1, fifo_hit2;

   // Handshake, request and grant decode. A full FIFO refuses even when it pops.
   assign LU_READY   = RESET & (count < DEPTH_C);
   assign push       = LU_V & LU_READY;
   assign enq        = push & (LU_DR != 5'd0);
   assign wb_req     = WB_V & WB_WEN & (WB_DR != 5'd0);
   assign wb_viol    = (state == DRAIN) & WB_V & WB_WEN;
   assign fifo_empty = (count == '0);
   assign pop        = ~fifo_empty & ~wb_req & ~wb_viol;
   assign count_nxt  = count + CW'(enq) - CW'(pop);

   // Starve counter next value: counts ARB cycles a waiting FIFO loses to WB.
   always_comb begin
      starve_nxt = starve_cnt;
      if (pop || fifo_empty)
         starve_nxt = '0;
      else if (state == ARB && wb_req && starve_cnt != LIMIT_C)
         starve_nxt = starve_cnt + SW'(1);
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         state <= ARB;
      else
         state <= state_nxt;
   end

   // FSM next state: force a drain on starvation or when WB fills the last slot.
   always_comb begin
      state_nxt = state;
      case (state)
         ARB: begin
            if (starve_nxt == LIMIT_C || (count_nxt == DEPTH_C && wb_req))
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (pop || fifo_empty)
               state_nxt = ARB;
         end
         default: state_nxt = ARB;
      endcase
   end

   // FSM outputs: the hold comes straight from the state flop so it is stable all cycle.
   always_comb begin
      PIPE_HOLD = 1'b0;
      if (state == DRAIN)
         PIPE_HOLD = 1'b1;
   end

   // FIFO control: pointers, occupancy and per-slot valid bits used for the interlock.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ent_vld <= '0;
      end else begin
         count <= count_nxt;
         if (enq) begin
            wr_ptr          <= wr_ptr + AW'(1);
            ent_vld[wr_ptr] <= 1'b1;
         end
         if (pop) begin
            rd_ptr          <= rd_ptr + AW'(1);
            ent_vld[rd_ptr] <= 1'b0;
         end
      end
   end

   // FIFO storage; contents are qualified by ent_vld so no reset is needed.
   always_ff @(posedge CLK) begin
      if (enq) begin
         mem_dr[wr_ptr]   <= LU_DR;
         mem_data[wr_ptr] <= LU_DATA;
      end
   end

   // Starve counter register.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         starve_cnt <= '0;
      else
         starve_cnt <= starve_nxt;
   end

   // Register-file write port: load the granted source, otherwise drop WEN and hold DR/data.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         OUT_DE_REG_WEN <= 1'b0;
         OUT_DE_DR      <= '0;
         OUT_DE_Data    <= '0;
      end else if (wb_req) begin
         OUT_DE_REG_WEN <= 1'b1;
         OUT_DE_DR      <= WB_DR;
         OUT_DE_Data    <= WB_DATA;
      end else if (pop) begin
         OUT_DE_REG_WEN <= 1'b1;
         OUT_DE_DR      <= mem_dr[rd_ptr];
         OUT_DE_Data    <= mem_data[rd_ptr];
      end else begin
         OUT_DE_REG_WEN <= 1'b0;
      end
   end

   // Sticky error: WB issued while the pipeline was told to hold.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         ERR <= 1'b0;
      else if (wb_viol)
         ERR <= 1'b1;
   end

   // Source-register match against every live FIFO entry.
   always_comb begin
      fifo_hit1 = 1'b0;
      fifo_hit2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i] && mem_dr[i] == SR1)
            fifo_hit1 = 1'b1;
         if (ent_vld[i] && mem_dr[i] == SR2)
            fifo_hit2 = 1'b1;
      end
   end

   // A write sitting in the output register has not committed yet, so it also pends.
   assign PEND1 = (SR1 != 5'd0) & (fifo_hit1 | (OUT_DE_REG_WEN & (OUT_DE_DR == SR1)));
   assign PEND2 = (SR2 != 5'd0) & (fifo_hit2 | (OUT_DE_REG_WEN & (OUT_DE_DR == SR2)));

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Covers reset, WB path, LU path, starvation drain, full drain, hold violation.
module tb_regfile_wr_arbiter;

   logic        CLK;
   logic        RESET;
   logic        WB_V, WB_WEN;
   logic [4:0]  WB_DR;
   logic [63:0] WB_DATA;
   logic        LU_V;
   logic [4:0]  LU_DR;
   logic [63:0] LU_DATA;
   logic        LU_READY;
   logic [4:0]  SR1, SR2;
   logic        PEND1, PEND2, PIPE_HOLD;
   logic [4:0]  OUT_DE_DR;
   logic [63:0] OUT_DE_Data;
   logic        OUT_DE_REG_WEN;
   logic        ERR;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_wr_arbiter #(.XLEN(64), .DEPTH(4), .STARVE_LIMIT(8)) dut (
      .CLK(CLK), .RESET(RESET),
      .WB_V(WB_V), .WB_WEN(WB_WEN), .WB_DR(WB_DR), .WB_DATA(WB_DATA),
      .LU_V(LU_V), .LU_DR(LU_DR), .LU_DATA(LU_DATA), .LU_READY(LU_READY),
      .SR1(SR1), .SR2(SR2), .PEND1(PEND1), .PEND2(PEND2),
      .PIPE_HOLD(PIPE_HOLD),
      .OUT_DE_DR(OUT_DE_DR), .OUT_DE_Data(OUT_DE_Data), .OUT_DE_REG_WEN(OUT_DE_REG_WEN),
      .ERR(ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic [4:0] dr, input logic [63:0] data);
      chk({tag, "_wen"}, 64'(OUT_DE_REG_WEN), 64'd1);
      chk({tag, "_dr"}, 64'(OUT_DE_DR), 64'(dr));
      chk({tag, "_data"}, OUT_DE_Data, data);
   endtask

   initial begin
      RESET = 1'b0;
      WB_V = 0; WB_WEN = 0; WB_DR = 0; WB_DATA = 0;
      LU_V = 0; LU_DR = 0; LU_DATA = 0;
      SR1 = 0; SR2 = 0;
      step();
      chk("rst_lu_ready_low", 64'(LU_READY), 64'd0);
      step();
      RESET = 1'b1;
      #1;
      chk("rst_wen", 64'(OUT_DE_REG_WEN), 64'd0);
      chk("rst_dr", 64'(OUT_DE_DR), 64'd0);
      chk("rst_data", OUT_DE_Data, 64'd0);
      chk("rst_hold", 64'(PIPE_HOLD), 64'd0);
      chk("rst_err", 64'(ERR), 64'd0);
      chk("rst_lu_ready_high", 64'(LU_READY), 64'd1);

      // WB path: one cycle to the write port; DR=0 writes nothing.
      WB_V = 1; WB_WEN = 1; WB_DR = 5; WB_DATA = 64'h1234; SR1 = 5;
      step();
      chk_wr("wb5", 5'd5, 64'h1234);
      chk("wb5_pend1", 64'(PEND1), 64'd1);
      WB_DR = 0; WB_DATA = 64'h9999;
      step();
      chk("wb0_wen", 64'(OUT_DE_REG_WEN), 64'd0);
      chk("wb0_dr_hold", 64'(OUT_DE_DR), 64'd5);
      chk("wb0_data_hold", OUT_DE_Data, 64'h1234);
      WB_V = 0; WB_WEN = 0;

      // LU path with WB idle: push at t, write visible at t+2, pend clears at t+3.
      LU_V = 1; LU_DR = 7; LU_DATA = 64'hAA; SR1 = 7;
      #1;
      chk("lu_t_pend1", 64'(PEND1), 64'd0);
      step();
      LU_V = 0;
      #1;
      chk("lu_t1_pend1", 64'(PEND1), 64'd1);
      chk("lu_t1_no_bypass", 64'(OUT_DE_REG_WEN), 64'd0);
      step();
      chk_wr("lu_t2", 5'd7, 64'hAA);
      chk("lu_t2_pend1", 64'(PEND1), 64'd1);
      step();
      chk("lu_t3_pend1", 64'(PEND1), 64'd0);
      chk("lu_t3_wen", 64'(OUT_DE_REG_WEN), 64'd0);

      // Starvation: WB writes every cycle, one LU entry waits eight losing cycles.
      WB_V = 1; WB_WEN = 1; WB_DR = 3; WB_DATA = 64'h33;
      LU_V = 1; LU_DR = 12; LU_DATA = 64'hBEEF; SR2 = 12;
      step();
      LU_V = 0;
      for (int k = 1; k <= 8; k++) begin
         chk("starve_no_hold", 64'(PIPE_HOLD), 64'd0);
         step();
      end
      chk("starve_hold", 64'(PIPE_HOLD), 64'd1);
      chk("starve_wb_last", 64'(OUT_DE_DR), 64'd3);
      chk("starve_pend2", 64'(PEND2), 64'd1);
      WB_V = 0; WB_WEN = 0;
      step();
      chk_wr("starve_drain", 5'd12, 64'hBEEF);
      chk("starve_hold_off", 64'(PIPE_HOLD), 64'd0);

      // Full FIFO: four pushes while WB wins, fifth refused, forced drain.
      WB_V = 1; WB_WEN = 1; WB_DR = 4; WB_DATA = 64'h44;
      for (int i = 0; i < 4; i++) begin
         LU_V = 1; LU_DR = 5'(20 + i); LU_DATA = 64'(256 + i);
         #1;
         chk("full_ready", 64'(LU_READY), 64'd1);
         step();
      end
      chk("full_ready_low", 64'(LU_READY), 64'd0);
      chk("full_hold", 64'(PIPE_HOLD), 64'd1);
      WB_V = 0; WB_WEN = 0;
      LU_V = 1; LU_DR = 30; LU_DATA = 64'hDEAD;
      step();
      LU_V = 0;
      chk_wr("full_pop0", 5'd20, 64'h100);
      chk("full_hold_off", 64'(PIPE_HOLD), 64'd0);
      chk("full_ready_back", 64'(LU_READY), 64'd1);
      step();
      chk_wr("full_pop1", 5'd21, 64'h101);
      step();
      chk_wr("full_pop2", 5'd22, 64'h102);
      step();
      chk_wr("full_pop3", 5'd23, 64'h103);
      step();
      chk("full_no_fifth", 64'(OUT_DE_REG_WEN), 64'd0);

      // Violation: WB keeps writing during the hold.
      WB_V = 1; WB_WEN = 1; WB_DR = 4; WB_DATA = 64'h44;
      for (int i = 0; i < 4; i++) begin
         LU_V = 1; LU_DR = 5'(8 + i); LU_DATA = 64'(512 + i);
         step();
      end
      LU_V = 0;
      chk("viol_hold", 64'(PIPE_HOLD), 64'd1);
      chk("viol_err_before", 64'(ERR), 64'd0);
      WB_DR = 9; WB_DATA = 64'h5555;
      step();
      chk_wr("viol_wb", 5'd9, 64'h5555);
      chk("viol_err", 64'(ERR), 64'd1);
      chk("viol_still_drain", 64'(PIPE_HOLD), 64'd1);
      chk("viol_no_pop_ready", 64'(LU_READY), 64'd0);
      WB_V = 0; WB_WEN = 0;
      step();
      chk_wr("viol_pop", 5'd8, 64'h200);
      chk("viol_arb", 64'(PIPE_HOLD), 64'd0);
      chk("viol_err_sticky", 64'(ERR), 64'd1);
      step();
      chk_wr("viol_pop1", 5'd9, 64'h201);

      // Reset with two entries queued: clears outputs, FIFO and ERR immediately.
      SR1 = 10;
      RESET = 1'b0;
      #1;
      chk("arst_wen", 64'(OUT_DE_REG_WEN), 64'd0);
      chk("arst_dr", 64'(OUT_DE_DR), 64'd0);
      chk("arst_ready", 64'(LU_READY), 64'd0);
      chk("arst_err", 64'(ERR), 64'd0);
      chk("arst_pend1", 64'(PEND1), 64'd0);
      step();
      RESET = 1'b1;
      #1;
      chk("arst_ready_rel", 64'(LU_READY), 64'd1);
      chk("arst_hold_rel", 64'(PIPE_HOLD), 64'd0);
      step();
      step();
      chk("arst_fifo_empty", 64'(OUT_DE_REG_WEN), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (OUT_DE_DR / OUT_DE_Data / OUT_DE_REG_WEN into decode_stage) between the in-order WB stage and a long-latency result source (mul/div, late load return).
- Buffers long-latency results in a small FIFO and stalls the pipeline for one cycle when those results are starved.
- Tells decode which source registers still have a buffered or in-flight write, so decode can interlock.

Parameters:
- XLEN, 64, data width.
- DEPTH, 4, long-latency FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may lose to WB before a forced drain; at least 1.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- WB_V  in  1  WB stage holds a valid instruction.
- WB_WEN  in  1  WB instruction writes a register.
- WB_DR  in  5  WB destination register.
- WB_DATA  in  XLEN  WB result.
- LU_V  in  1  long-latency result valid.
- LU_DR  in  5  long-latency destination register.
- LU_DATA  in  XLEN  long-latency result.
- LU_READY  out  1  FIFO can accept this cycle.
- SR1  in  5  decode source register 1.
- SR2  in  5  decode source register 2.
- PEND1  out  1  SR1 has a pending long-latency or in-flight write.
- PEND2  out  1  SR2 has a pending long-latency or in-flight write.
- PIPE_HOLD  out  1  pipeline must present WB_V=0 this cycle.
- OUT_DE_DR  out  5  register-file write address.
- OUT_DE_Data  out  XLEN  register-file write data.
- OUT_DE_REG_WEN  out  1  register-file write enable.
- ERR  out  1  sticky protocol violation flag.

Behaviour:
- Reset (RESET=0, takes effect immediately):
  - OUT_DE_REG_WEN=0, OUT_DE_DR=0, OUT_DE_Data=0, PIPE_HOLD=0, ERR=0.
  - FIFO count, pointers and starve counter cleared; FSM set to ARB.
  - LU_READY forced to 0 while reset is asserted.
- LU_READY = (count < DEPTH) and not in reset. It is based on the count at the start of the cycle, so a full FIFO refuses a push even in a cycle where it pops.
- Push: LU_V & LU_READY. An entry with LU_DR=0 is handshaken but not enqueued.
- WB request: WB_V & WB_WEN & (WB_DR != 0). When WB_DR=0, no write occurs.
- Grant, evaluated every cycle:
  - A WB request always wins.
  - Otherwise a non-empty FIFO pops its head.
  - Otherwise no write.
- Output registers load the granted DR/data with WEN=1 at the clock edge. With no grant, WEN goes to 0 and DR/data hold.
- Latency:
  - WB path: 1 cycle.
  - LU path: at least 2 cycles. There is no bypass; an entry pushed into an empty FIFO pops on the next cycle at the earliest.
- Starve counter:
  - Increments in each ARB cycle where the FIFO is non-empty and WB wins.
  - Clears on any pop or when the FIFO is empty.
- FSM states:
  - ARB: normal arbitration, PIPE_HOLD=0.
    - Go to DRAIN when the starve counter reaches STARVE_LIMIT.
    - Also go to DRAIN when the FIFO is full (count=DEPTH after this edge) and WB won this cycle.
  - DRAIN: PIPE_HOLD=1 (registered, so valid the whole cycle). The FIFO head pops.
    - Go to ARB after a pop.
    - If WB_V & WB_WEN arrive anyway: WB wins, ERR is set, the FSM stays in DRAIN.
- PEND1/PEND2 (combinational):
  - Asserted when SRx != 0 and SRx matches the DR of any valid FIFO entry.
  - Also asserted when SRx matches OUT_DE_DR while OUT_DE_REG_WEN=1; that write commits at the next edge.
  - SRx=0 never pends.
- Ordering:
  - The FIFO is strictly in order.
  - No ordering is enforced between WB and FIFO writes to the same DR. Decode must not issue an instruction whose rd or rs has PEND set (covers WAW and RAW).
- ERR is sticky and is cleared only by reset.

Test Plan:
- Reset: drive RESET=0 with 2 FIFO entries queued, then release -> immediately OUT_DE_REG_WEN=0, LU_READY=0 during reset, LU_READY=1 after release, PIPE_HOLD=0, ERR=0.
- WB write: WB_V=1, WB_WEN=1, WB_DR=5, WB_DATA=0x1234 -> next cycle OUT_DE_REG_WEN=1, OUT_DE_DR=5, OUT_DE_Data=0x1234. Repeat with WB_DR=0 -> OUT_DE_REG_WEN=0.
- LU write with WB idle: push LU_DR=7, LU_DATA=0xAA at cycle t; SR1=7 -> PEND1=1 in cycles t+1 and t+2; register-file write of 7/0xAA visible at t+2; PEND1=0 at t+3.
- Starvation: WB writes every cycle, one LU entry pushed -> after 8 losing cycles PIPE_HOLD=1 for exactly one cycle; entry drains in that cycle; PIPE_HOLD=0 next cycle.
- Full FIFO: push 4 entries while WB writes every cycle -> LU_READY=0 once count=4; a 5th LU_V is not accepted; PIPE_HOLD=1 on the next cycle; count drops to 3.
- Violation: hold WB_V=1, WB_WEN=1 during PIPE_HOLD=1 -> WB is written, head does not pop, ERR=1, FSM stays DRAIN. Then drop WB_V -> head pops, return to ARB, ERR stays 1.
